// File: rtl/mem_wb_pipe.sv
`default_nettype none
`timescale 1ns/1ps
// +---------------------------------------------------------------------------+
// | mem_wb_pipe : MEM/WB register, NLANE write lanes, 2-entry skid, retire ctr |
// | rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module mem_wb_pipe #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int NLANE        = 1,
  parameter int ZERO_DISCARD = 1,
  parameter int CNT_W        = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NLANE-1:0]        wreg_i,
  input  logic [NLANE*ADDR_W-1:0] waddr_i,
  input  logic [NLANE*DATA_W-1:0] wdata_i,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NLANE-1:0]        wreg_o,
  output logic [NLANE*ADDR_W-1:0] waddr_o,
  output logic [NLANE*DATA_W-1:0] wdata_o,
  output logic [CNT_W-1:0]        retire_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic                    main_v_q,    main_v_d;
  logic                    skid_v_q,    skid_v_d;
  logic [NLANE-1:0]        main_wreg_q, main_wreg_d;
  logic [NLANE*ADDR_W-1:0] main_addr_q, main_addr_d;
  logic [NLANE*DATA_W-1:0] main_data_q, main_data_d;
  logic [NLANE-1:0]        skid_wreg_q, skid_wreg_d;
  logic [NLANE*ADDR_W-1:0] skid_addr_q, skid_addr_d;
  logic [NLANE*DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CNT_W-1:0]        cnt_q,       cnt_d;

  logic [NLANE-1:0] in_wreg;
  logic             accept;
  logic             deliver;

  // Writes to x0 are neutralised on entry so the stored enable is already final.
  for (genvar k = 0; k < NLANE; k++) begin : g_lane
    assign in_wreg[k] = wreg_i[k] &
                        ~((ZERO_DISCARD != 0) && (waddr_i[k*ADDR_W +: ADDR_W] == '0));
  end

  assign accept  = in_valid & ~skid_v_q;
  assign deliver = main_v_q & out_ready;

  always_comb begin
    main_v_d    = main_v_q;
    skid_v_d    = skid_v_q;
    main_wreg_d = main_wreg_q;
    main_addr_d = main_addr_q;
    main_data_d = main_data_q;
    skid_wreg_d = skid_wreg_q;
    skid_addr_d = skid_addr_q;
    skid_data_d = skid_data_q;
    cnt_d       = cnt_q;

    if (deliver) begin
      cnt_d = cnt_q + CNT_ONE;
    end

    if (flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (!main_v_q) begin
      if (accept) begin
        main_v_d    = 1'b1;
        main_wreg_d = in_wreg;
        main_addr_d = waddr_i;
        main_data_d = wdata_i;
      end
    end else if (deliver) begin
      // Skid always drains first; in_ready is low whenever it is occupied.
      if (skid_v_q) begin
        main_wreg_d = skid_wreg_q;
        main_addr_d = skid_addr_q;
        main_data_d = skid_data_q;
        skid_v_d    = 1'b0;
      end else if (accept) begin
        main_wreg_d = in_wreg;
        main_addr_d = waddr_i;
        main_data_d = wdata_i;
      end else begin
        main_v_d = 1'b0;
      end
    end else if (accept) begin
      skid_v_d    = 1'b1;
      skid_wreg_d = in_wreg;
      skid_addr_d = waddr_i;
      skid_data_d = wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_v_q    <= 1'b0;
      skid_v_q    <= 1'b0;
      main_wreg_q <= '0;
      main_addr_q <= '0;
      main_data_q <= '0;
      skid_wreg_q <= '0;
      skid_addr_q <= '0;
      skid_data_q <= '0;
      cnt_q       <= '0;
    end else begin
      main_v_q    <= main_v_d;
      skid_v_q    <= skid_v_d;
      main_wreg_q <= main_wreg_d;
      main_addr_q <= main_addr_d;
      main_data_q <= main_data_d;
      skid_wreg_q <= skid_wreg_d;
      skid_addr_q <= skid_addr_d;
      skid_data_q <= skid_data_d;
      cnt_q       <= cnt_d;
    end
  end

  assign in_ready   = ~skid_v_q;
  assign out_valid  = main_v_q;
  assign wreg_o     = main_wreg_q & {NLANE{main_v_q}};
  assign waddr_o    = main_addr_q;
  assign wdata_o    = main_data_q;
  assign retire_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_pipe.sv
`default_nettype none
`timescale 1ns/1ps
// tb_mem_wb_pipe : directed + randomized checks against a 2-deep queue model.
module tb_mem_wb_pipe;

  typedef struct packed {
    logic [1:0]  w;
    logic [9:0]  a;
    logic [63:0] d;
  } bundle_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  wreg_i;
  logic [9:0]  waddr_i;
  logic [63:0] wdata_i;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  wreg_o;
  logic [9:0]  waddr_o;
  logic [63:0] wdata_o;
  logic [3:0]  retire_cnt;

  bundle_t     mq[$];
  logic [3:0]  m_cnt;
  int          total = 0;
  int          bad   = 0;

  mem_wb_pipe #(
    .DATA_W(32), .ADDR_W(5), .NLANE(2), .ZERO_DISCARD(1), .CNT_W(4)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .wreg_i(wreg_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .wreg_o(wreg_o), .waddr_o(waddr_o), .wdata_o(wdata_o),
    .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic bundle_t rnd_b();
    bundle_t     b;
    logic [31:0] t;
    t = $urandom;
    b.w = t[1:0];
    b.a[4:0] = ($urandom_range(0, 3) == 0) ? 5'd0 : t[6:2];
    b.a[9:5] = ($urandom_range(0, 3) == 0) ? 5'd0 : t[11:7];
    b.d = {$urandom, $urandom};
    return b;
  endfunction

  // A lane only writes when enabled and not targeting x0.
  function automatic logic [1:0] exp_wreg(bundle_t b);
    logic [1:0] e;
    for (int k = 0; k < 2; k++) e[k] = b.w[k] && (b.a[k*5 +: 5] != 5'd0);
    return e;
  endfunction

  task automatic drive(input bundle_t b);
    wreg_i  = b.w;
    waddr_i = b.a;
    wdata_i = b.d;
  endtask

  // One clock: update the queue model from the inputs present at the edge.
  task automatic step();
    bundle_t cur;
    bit      acc;
    bit      del;
    @(posedge clk);
    if (rst) begin
      cur = {wreg_i, waddr_i, wdata_i};
      acc = in_valid && (mq.size() < 2);
      del = (mq.size() > 0) && out_ready;
      if (del) begin
        void'(mq.pop_front());
        m_cnt = m_cnt + 4'd1;
      end
      if (flush) mq.delete();
      else if (acc) mq.push_back(cur);
    end
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    wreg_i = '0; waddr_i = '0; wdata_i = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b want=1", in_ready); end
    total++; if (wreg_o !== 2'b00) begin bad++; $display("FAIL reset_wreg got=%b want=00", wreg_o); end
    total++; if (waddr_o !== 10'd0 || wdata_o !== 64'd0) begin bad++; $display("FAIL reset_addr_data got=%h/%h want=0/0", waddr_o, wdata_o); end
    total++; if (retire_cnt !== 4'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", retire_cnt); end
    mq.delete(); m_cnt = 4'd0;
    rst = 1'b1;
  endtask

  task automatic test_single();
    bundle_t b;
    b.w = 2'b01; b.a = {5'd0, 5'd5}; b.d = {32'h0, 32'hDEADBEEF};
    drive(b); in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%0b want=1", out_valid); end
    total++; if (waddr_o[4:0] !== 5'd5) begin bad++; $display("FAIL single_addr got=%0d want=5", waddr_o[4:0]); end
    total++; if (wdata_o[31:0] !== 32'hDEADBEEF) begin bad++; $display("FAIL single_data got=%h want=deadbeef", wdata_o[31:0]); end
    total++; if (wreg_o !== 2'b01) begin bad++; $display("FAIL single_wreg got=%b want=01", wreg_o); end
    total++; if (retire_cnt !== 4'd0) begin bad++; $display("FAIL single_cnt_pre got=%0d want=0", retire_cnt); end
    step();
    total++; if (retire_cnt !== 4'd1) begin bad++; $display("FAIL single_cnt_post got=%0d want=1", retire_cnt); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_drained got=%0b want=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    bundle_t    x[3];
    logic [3:0] c0;
    c0 = retire_cnt;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      x[i] = rnd_b(); x[i].w = 2'b11; x[i].a = {5'd7 + 5'(i), 5'd1 + 5'(i)};
      drive(x[i]); in_valid = 1'b1;
      step();
    end
    total++; if (out_valid !== 1'b1 || wdata_o !== x[0].d) begin bad++; $display("FAIL b2b_hold got=%0b/%h want=1/%h", out_valid, wdata_o, x[0].d); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_full got=%0b want=0", in_ready); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total++; if (out_valid !== 1'b1 || wdata_o !== x[i].d) begin bad++; $display("FAIL b2b_order%0d got=%0b/%h want=1/%h", i, out_valid, wdata_o, x[i].d); end
      step();
      if (i == 1) in_valid = 1'b0;
    end
    total++; if (retire_cnt !== c0 + 4'd3) begin bad++; $display("FAIL b2b_cnt got=%0d want=%0d", retire_cnt, c0 + 4'd3); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_empty got=%0b want=0", out_valid); end
  endtask

  task automatic test_flush();
    logic [3:0] c0;
    c0 = retire_cnt;
    out_ready = 1'b0;
    repeat (2) begin drive(rnd_b()); in_valid = 1'b1; step(); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_prefull got=%0b want=0", in_ready); end
    drive(rnd_b()); flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL flush_clear got=v%0b r%0b want=v0 r1", out_valid, in_ready); end
    total++; if (retire_cnt !== c0 || wreg_o !== 2'b00) begin bad++; $display("FAIL flush_cnt got=%0d/%b want=%0d/00", retire_cnt, wreg_o, c0); end
    drive(rnd_b()); in_valid = 1'b1;
    step();
    in_valid = 1'b0; out_ready = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0;
    total++; if (retire_cnt !== c0 + 4'd1 || out_valid !== 1'b0) begin bad++; $display("FAIL flush_deliver got=%0d/%0b want=%0d/0", retire_cnt, out_valid, c0 + 4'd1); end
  endtask

  task automatic test_zero_discard();
    bundle_t b;
    b.w = 2'b11; b.a = {5'd3, 5'd0}; b.d = {$urandom, $urandom};
    out_ready = 1'b0; drive(b); in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    total++; if (wreg_o !== 2'b10) begin bad++; $display("FAIL zero_wreg got=%b want=10", wreg_o); end
    total++; if (waddr_o !== {5'd3, 5'd0} || wdata_o !== b.d) begin bad++; $display("FAIL zero_stored got=%h/%h want=%h/%h", waddr_o, wdata_o, {5'd3, 5'd0}, b.d); end
    out_ready = 1'b1;
    step();
  endtask

  task automatic test_wrap();
    idle_inputs();
    #2 rst = 1'b0;
    #1 rst = 1'b1;
    mq.delete(); m_cnt = 4'd0;
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin drive(rnd_b()); step(); end
    in_valid = 1'b0;
    step();
    total++; if (retire_cnt !== 4'd1) begin bad++; $display("FAIL wrap_cnt got=%0d want=1", retire_cnt); end
  endtask

  task automatic test_random();
    bundle_t f;
    for (int n = 0; n < 400; n++) begin
      drive(rnd_b());
      in_valid  = ($urandom_range(0, 9) < 6);
      out_ready = ($urandom_range(0, 9) < 5);
      flush     = ($urandom_range(0, 15) == 0);
      #1;
      total++; if (out_valid !== (mq.size() != 0) || in_ready !== (mq.size() < 2)) begin bad++; $display("FAIL rnd_hs cyc=%0d got=v%0b r%0b want=v%0b r%0b", n, out_valid, in_ready, mq.size() != 0, mq.size() < 2); end
      total++; if (retire_cnt !== m_cnt) begin bad++; $display("FAIL rnd_cnt cyc=%0d got=%0d want=%0d", n, retire_cnt, m_cnt); end
      if (mq.size() != 0) begin
        f = mq[0];
        total++; if (wreg_o !== exp_wreg(f) || waddr_o !== f.a || wdata_o !== f.d) begin bad++; $display("FAIL rnd_data cyc=%0d got=%b/%h/%h want=%b/%h/%h", n, wreg_o, waddr_o, wdata_o, exp_wreg(f), f.a, f.d); end
      end else begin
        total++; if (wreg_o !== 2'b00) begin bad++; $display("FAIL rnd_wreg_idle cyc=%0d got=%b want=00", n, wreg_o); end
      end
      step();
    end
    flush = 1'b0;
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    repeat (2) begin drive(rnd_b()); in_valid = 1'b1; step(); end
    for (int i = 0; i < 3; i++) begin
      out_ready = ~out_ready; drive(rnd_b());
      step();
    end
    out_ready = 1'b0;
    in_valid = 1'b1;
    step();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL areset_pre got=%0b want=1", out_valid); end
    #2 rst = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL areset_hs got=v%0b r%0b want=v0 r1", out_valid, in_ready); end
    total++; if (wreg_o !== 2'b00 || waddr_o !== 10'd0 || wdata_o !== 64'd0 || retire_cnt !== 4'd0) begin bad++; $display("FAIL areset_out got=%b/%h/%h/%0d want=0", wreg_o, waddr_o, wdata_o, retire_cnt); end
    idle_inputs();
    mq.delete(); m_cnt = 4'd0;
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_flush();
    test_zero_discard();
    test_wrap();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
